// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-lookup, commit and flush signals of the reorder buffer.
// The ROB binds to the slave modport; the surrounding core binds to master.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH  = 4,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  rdy_in;

    logic                  rdy_dp_in;
    logic                  has_dest_dp_in;
    logic [REG_WIDTH-1:0]  dest_dp_in;
    logic                  is_branch_dp_in;
    logic                  pred_taken_dp_in;
    logic [ROB_WIDTH-1:0]  rob_id_dp_out;
    logic                  full_out;

    logic [ROB_WIDTH-1:0]  q1_id_in;
    logic [ROB_WIDTH-1:0]  q2_id_in;
    logic                  q1_ready_out;
    logic                  q2_ready_out;
    logic [DATA_WIDTH-1:0] q1_val_out;
    logic [DATA_WIDTH-1:0] q2_val_out;

    logic                  rdy_cdb_in;
    logic [ROB_WIDTH-1:0]  rob_id_cdb_in;
    logic [DATA_WIDTH-1:0] value_cdb_in;
    logic                  taken_cdb_in;
    logic [DATA_WIDTH-1:0] target_cdb_in;

    logic                  rdy_commit_out;
    logic [REG_WIDTH-1:0]  dest_out;
    logic [DATA_WIDTH-1:0] value_out;
    logic [ROB_WIDTH-1:0]  rob_id_out;
    logic                  refresh_out;
    logic [DATA_WIDTH-1:0] pc_out;

    modport master (
        output rdy_in,
        output rdy_dp_in, has_dest_dp_in, dest_dp_in, is_branch_dp_in, pred_taken_dp_in,
        input  rob_id_dp_out, full_out,
        output q1_id_in, q2_id_in,
        input  q1_ready_out, q2_ready_out, q1_val_out, q2_val_out,
        output rdy_cdb_in, rob_id_cdb_in, value_cdb_in, taken_cdb_in, target_cdb_in,
        input  rdy_commit_out, dest_out, value_out, rob_id_out, refresh_out, pc_out
    );

    modport slave (
        input  rdy_in,
        input  rdy_dp_in, has_dest_dp_in, dest_dp_in, is_branch_dp_in, pred_taken_dp_in,
        output rob_id_dp_out, full_out,
        input  q1_id_in, q2_id_in,
        output q1_ready_out, q2_ready_out, q1_val_out, q2_val_out,
        input  rdy_cdb_in, rob_id_cdb_in, value_cdb_in, taken_cdb_in, target_cdb_in,
        output rdy_commit_out, dest_out, value_out, rob_id_out, refresh_out, pc_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, CDB result capture, in-order
// retirement into the register file and mispredict flush.
module reorder_buffer #(
    parameter int ROB_WIDTH  = 4,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk_in,
    input logic             rst_in,
    reorder_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH + 1)'(DEPTH);

    // Entry control state (reset) and entry payload (not reset)
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      ready;
    logic [DEPTH-1:0]      has_dest;
    logic [DEPTH-1:0]      is_branch;
    logic [DEPTH-1:0]      pred_taken;
    logic [DEPTH-1:0]      taken;
    logic [REG_WIDTH-1:0]  dest   [DEPTH];
    logic [DATA_WIDTH-1:0] value  [DEPTH];
    logic [DATA_WIDTH-1:0] target [DEPTH];

    logic [ROB_WIDTH-1:0]  head;
    logic [ROB_WIDTH-1:0]  tail;
    logic [ROB_WIDTH:0]    count;

    logic                  commit_p1;
    logic [REG_WIDTH-1:0]  dest_p1;
    logic [DATA_WIDTH-1:0] value_p1;
    logic [ROB_WIDTH-1:0]  rob_id_p1;
    logic                  refresh_p1;
    logic [DATA_WIDTH-1:0] pc_p1;

    logic full;
    logic do_commit;
    logic mispredict;
    logic do_alloc;
    logic cdb_wr;
    logic q1_hit;
    logic q2_hit;

    // x0 is hardwired to zero, so a commit to it never carries a value
    function automatic logic [DATA_WIDTH-1:0] commit_value(
        input logic [REG_WIDTH-1:0]  rd,
        input logic [DATA_WIDTH-1:0] val
    );
        return (rd == '0) ? '0 : val;
    endfunction

    always_comb begin
        full       = (count == FULL_CNT);
        do_commit  = (count != '0) && ready[head] && !refresh_p1;
        mispredict = do_commit && is_branch[head] && (taken[head] != pred_taken[head]);
        do_alloc   = bus.rdy_dp_in && !full && !refresh_p1 && !mispredict;
        cdb_wr     = bus.rdy_cdb_in && busy[bus.rob_id_cdb_in] && !refresh_p1 && !mispredict;
    end

    // Operand lookup with same-cycle CDB bypass
    always_comb begin
        q1_hit = bus.rdy_cdb_in && (bus.rob_id_cdb_in == bus.q1_id_in);
        q2_hit = bus.rdy_cdb_in && (bus.rob_id_cdb_in == bus.q2_id_in);
    end

    assign bus.q1_ready_out = q1_hit || ready[bus.q1_id_in];
    assign bus.q2_ready_out = q2_hit || ready[bus.q2_id_in];
    assign bus.q1_val_out   = q1_hit ? bus.value_cdb_in : value[bus.q1_id_in];
    assign bus.q2_val_out   = q2_hit ? bus.value_cdb_in : value[bus.q2_id_in];

    assign bus.full_out      = full;
    assign bus.rob_id_dp_out = tail;

    // Control state, pointers and the registered commit/flush outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            busy       <= '0;
            ready      <= '0;
            commit_p1  <= 1'b0;
            refresh_p1 <= 1'b0;
            dest_p1    <= '0;
            value_p1   <= '0;
            rob_id_p1  <= '0;
            pc_p1      <= '0;
        end else if (bus.rdy_in) begin
            commit_p1  <= do_commit && has_dest[head];
            refresh_p1 <= mispredict;
            if (do_commit) begin
                dest_p1   <= dest[head];
                value_p1  <= commit_value(dest[head], value[head]);
                rob_id_p1 <= head;
            end
            if (mispredict) begin
                pc_p1 <= target[head];
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_wr) begin
                    ready[bus.rob_id_cdb_in] <= 1'b1;
                end
                // Freeing the head comes after the CDB write so it wins on a collision
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (do_alloc && !do_commit) begin
                    count <= count + 1'b1;
                end else if (!do_alloc && do_commit) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Entry payload; meaningful only while the matching busy bit is set
    always_ff @(posedge clk_in) begin
        if (!rst_in && bus.rdy_in) begin
            if (do_alloc) begin
                has_dest[tail]   <= bus.has_dest_dp_in;
                dest[tail]       <= bus.dest_dp_in;
                is_branch[tail]  <= bus.is_branch_dp_in;
                pred_taken[tail] <= bus.pred_taken_dp_in;
            end
            if (cdb_wr) begin
                value[bus.rob_id_cdb_in]  <= bus.value_cdb_in;
                taken[bus.rob_id_cdb_in]  <= bus.taken_cdb_in;
                target[bus.rob_id_cdb_in] <= bus.target_cdb_in;
            end
        end
    end

    assign bus.rdy_commit_out = commit_p1;
    assign bus.dest_out       = dest_p1;
    assign bus.value_out      = value_p1;
    assign bus.rob_id_out     = rob_id_p1;
    assign bus.refresh_out    = refresh_p1;
    assign bus.pc_out         = pc_p1;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a queue-based model of program-order retirement.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    reorder_buffer_if #(.ROB_WIDTH(4), .REG_WIDTH(5), .DATA_WIDTH(32)) rif ();

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        has_dest;
        logic [4:0]  dest;
        logic        is_branch;
        logic        pred;
        logic        ready;
        logic        taken;
        logic [31:0] value;
        logic [31:0] target;
    } ent_t;

    // Model: live instructions in program order, plus expected registered outputs
    ent_t        mq[$];
    int          m_tail = 0;
    logic        e_commit = 1'b0;
    logic        e_refresh = 1'b0;
    logic [4:0]  e_dest = '0;
    logic [31:0] e_value = '0;
    logic [31:0] e_pc = '0;
    logic [3:0]  e_rid = '0;

    function automatic void model_update();
        bit   full_pre;
        bit   flush;
        ent_t h;
        ent_t n;
        if (rst) begin
            mq.delete();
            m_tail = 0;
            e_commit = 0; e_refresh = 0; e_dest = 0; e_value = 0; e_pc = 0; e_rid = 0;
        end else if (rif.rdy_in) begin
            if (e_refresh) begin
                e_refresh = 0;
                e_commit  = 0;
            end else begin
                full_pre = (mq.size() == 16);
                flush    = 0;
                if (mq.size() > 0 && mq[0].ready) begin
                    h = mq.pop_front();
                    e_commit = h.has_dest;
                    e_dest   = h.dest;
                    e_value  = (h.dest == 0) ? 32'd0 : h.value;
                    e_rid    = 4'(h.id);
                    if (h.is_branch && (h.taken != h.pred)) begin
                        flush = 1;
                        e_pc  = h.target;
                    end
                end else begin
                    e_commit = 0;
                end
                e_refresh = flush;
                if (flush) begin
                    mq.delete();
                    m_tail = 0;
                end else begin
                    if (rif.rdy_cdb_in) begin
                        foreach (mq[i]) begin
                            if (mq[i].id == int'(rif.rob_id_cdb_in)) begin
                                mq[i].ready  = 1;
                                mq[i].value  = rif.value_cdb_in;
                                mq[i].taken  = rif.taken_cdb_in;
                                mq[i].target = rif.target_cdb_in;
                            end
                        end
                    end
                    if (rif.rdy_dp_in && !full_pre) begin
                        n.id = m_tail; n.has_dest = rif.has_dest_dp_in; n.dest = rif.dest_dp_in;
                        n.is_branch = rif.is_branch_dp_in; n.pred = rif.pred_taken_dp_in;
                        n.ready = 0; n.taken = 0; n.value = 0; n.target = 0;
                        mq.push_back(n);
                        m_tail = (m_tail + 1) % 16;
                    end
                end
            end
        end
    endfunction

    function automatic void model_lookup(input logic [3:0] id, output logic r, output logic [31:0] v);
        r = 0;
        v = 0;
        if (rif.rdy_cdb_in && rif.rob_id_cdb_in == id) begin
            r = 1;
            v = rif.value_cdb_in;
        end else begin
            foreach (mq[i]) begin
                if (mq[i].id == int'(id) && mq[i].ready) begin
                    r = 1;
                    v = mq[i].value;
                end
            end
        end
    endfunction

    task automatic idle();
        rif.rdy_in = 1; rif.rdy_dp_in = 0; rif.has_dest_dp_in = 0; rif.dest_dp_in = 0;
        rif.is_branch_dp_in = 0; rif.pred_taken_dp_in = 0; rif.q1_id_in = 0; rif.q2_id_in = 0;
        rif.rdy_cdb_in = 0; rif.rob_id_cdb_in = 0; rif.value_cdb_in = 0;
        rif.taken_cdb_in = 0; rif.target_cdb_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic alloc(input logic hd, input logic [4:0] d, input logic br, input logic pr);
        rif.rdy_dp_in = 1; rif.has_dest_dp_in = hd; rif.dest_dp_in = d;
        rif.is_branch_dp_in = br; rif.pred_taken_dp_in = pr;
        tick();
        rif.rdy_dp_in = 0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        rif.rdy_cdb_in = 1; rif.rob_id_cdb_in = id; rif.value_cdb_in = v;
        rif.taken_cdb_in = tk; rif.target_cdb_in = tg;
        tick();
        rif.rdy_cdb_in = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rif.rdy_in = 0;
        rst = 1;
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", rif.rdy_commit_out); end
        n_cmp++; if (rif.refresh_out !== 1'b0) begin n_fail++; $display("FAIL reset_refresh: got %b want 0", rif.refresh_out); end
        n_cmp++; if (rif.pc_out !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", rif.pc_out); end
        n_cmp++; if (rif.dest_out !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %h want 0", rif.dest_out); end
        n_cmp++; if (rif.value_out !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %h want 0", rif.value_out); end
        n_cmp++; if (rif.rob_id_out !== 4'd0) begin n_fail++; $display("FAIL reset_rob_id: got %h want 0", rif.rob_id_out); end
        n_cmp++; if (rif.full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", rif.full_out); end
        n_cmp++; if (rif.rob_id_dp_out !== 4'd0) begin n_fail++; $display("FAIL reset_tail: got %h want 0", rif.rob_id_dp_out); end
        rst = 0;
        rif.rdy_in = 1;
    endtask

    task automatic test_in_order();
        do_reset();
        alloc(1, 5'd1, 0, 0);
        alloc(1, 5'd2, 0, 0);
        alloc(1, 5'd3, 0, 0);
        cdb(4'd2, 32'd30, 0, 0);
        cdb(4'd0, 32'd10, 0, 0);
        cdb(4'd1, 32'd20, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_cmp++; if (rif.rdy_commit_out !== 1'b1) begin n_fail++; $display("FAIL order_commit%0d: got %b want 1", i, rif.rdy_commit_out); end
            n_cmp++; if (rif.dest_out !== 5'(i + 1)) begin n_fail++; $display("FAIL order_dest%0d: got %0d want %0d", i, rif.dest_out, i + 1); end
            n_cmp++; if (rif.value_out !== 32'((i + 1) * 10)) begin n_fail++; $display("FAIL order_value%0d: got %0d want %0d", i, rif.value_out, (i + 1) * 10); end
            n_cmp++; if (rif.rob_id_out !== 4'(i)) begin n_fail++; $display("FAIL order_rob_id%0d: got %0d want %0d", i, rif.rob_id_out, i); end
        end
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL order_idle: got %b want 0", rif.rdy_commit_out); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(1, 5'(i + 1), 0, 0);
        n_cmp++; if (rif.full_out !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", rif.full_out); end
        n_cmp++; if (rif.rob_id_dp_out !== 4'd0) begin n_fail++; $display("FAIL fill_wrap_tail: got %0d want 0", rif.rob_id_dp_out); end
        alloc(1, 5'd31, 0, 0);
        n_cmp++; if (rif.rob_id_dp_out !== 4'd0) begin n_fail++; $display("FAIL fill_17th_tail: got %0d want 0", rif.rob_id_dp_out); end
        for (int i = 0; i < 16; i++) begin
            cdb(4'(i), 32'(i * 3 + 1), 0, 0);
            if (i > 0) begin
                n_cmp++; if (rif.rob_id_out !== 4'(i - 1) || rif.value_out !== 32'((i - 1) * 3 + 1) || rif.rdy_commit_out !== 1'b1)
                    begin n_fail++; $display("FAIL fill_retire%0d: got id %0d val %0d pulse %b want id %0d val %0d pulse 1", i - 1, rif.rob_id_out, rif.value_out, rif.rdy_commit_out, i - 1, (i - 1) * 3 + 1); end
            end
        end
        tick();
        n_cmp++; if (rif.rob_id_out !== 4'd15 || rif.dest_out !== 5'd16) begin n_fail++; $display("FAIL fill_last: got id %0d dest %0d want 15/16", rif.rob_id_out, rif.dest_out); end
        n_cmp++; if (rif.full_out !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got %b want 0", rif.full_out); end
        alloc(1, 5'd4, 0, 0);
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL fill_no_17th: got %b want 0", rif.rdy_commit_out); end
        n_cmp++; if (rif.rob_id_dp_out !== 4'd1) begin n_fail++; $display("FAIL fill_realloc: got %0d want 1", rif.rob_id_dp_out); end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 6; i++) alloc(1, 5'(i + 1), 0, 0);
        rif.q1_id_in = 4'd5; rif.q2_id_in = 4'd4;
        rif.rdy_cdb_in = 1; rif.rob_id_cdb_in = 4'd5; rif.value_cdb_in = 32'hDEAD;
        #1;
        n_cmp++; if (rif.q1_ready_out !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %b want 1", rif.q1_ready_out); end
        n_cmp++; if (rif.q1_val_out !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_val: got %h want dead", rif.q1_val_out); end
        n_cmp++; if (rif.q2_ready_out !== 1'b0) begin n_fail++; $display("FAIL bypass_other: got %b want 0", rif.q2_ready_out); end
        tick();
        rif.rdy_cdb_in = 0;
        #1;
        n_cmp++; if (rif.q1_ready_out !== 1'b1 || rif.q1_val_out !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_stored: got %b/%h want 1/dead", rif.q1_ready_out, rif.q1_val_out); end
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(0, 5'd0, 1, 0);
        alloc(1, 5'd4, 0, 0);
        alloc(1, 5'd5, 0, 0);
        cdb(4'd1, 32'd44, 0, 0);
        cdb(4'd0, 32'd0, 1, 32'h1000);
        tick();
        n_cmp++; if (rif.refresh_out !== 1'b1) begin n_fail++; $display("FAIL mp_refresh: got %b want 1", rif.refresh_out); end
        n_cmp++; if (rif.pc_out !== 32'h1000) begin n_fail++; $display("FAIL mp_pc: got %h want 1000", rif.pc_out); end
        n_cmp++; if (rif.rdy_commit_out !== 1'b0 || rif.rob_id_out !== 4'd0) begin n_fail++; $display("FAIL mp_branch_commit: got %b/%0d want 0/0", rif.rdy_commit_out, rif.rob_id_out); end
        rif.rdy_dp_in = 1; rif.has_dest_dp_in = 1; rif.dest_dp_in = 5'd7;
        tick();
        rif.rdy_dp_in = 0;
        n_cmp++; if (rif.refresh_out !== 1'b0) begin n_fail++; $display("FAIL mp_one_cycle: got %b want 0", rif.refresh_out); end
        n_cmp++; if (rif.rob_id_dp_out !== 4'd0) begin n_fail++; $display("FAIL mp_tail: got %0d want 0", rif.rob_id_dp_out); end
        n_cmp++; if (rif.full_out !== 1'b0) begin n_fail++; $display("FAIL mp_full: got %b want 0", rif.full_out); end
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL mp_flushed: got %b want 0", rif.rdy_commit_out); end
        alloc(1, 5'd9, 0, 0);
        n_cmp++; if (rif.rob_id_dp_out !== 4'd1) begin n_fail++; $display("FAIL mp_restart: got %0d want 1", rif.rob_id_dp_out); end
    endtask

    task automatic test_x0_nodest();
        do_reset();
        alloc(1, 5'd0, 0, 0);
        alloc(0, 5'd5, 0, 0);
        cdb(4'd0, 32'd7, 0, 0);
        cdb(4'd1, 32'd99, 0, 0);
        n_cmp++; if (rif.rdy_commit_out !== 1'b1 || rif.dest_out !== 5'd0) begin n_fail++; $display("FAIL x0_commit: got %b/%0d want 1/0", rif.rdy_commit_out, rif.dest_out); end
        n_cmp++; if (rif.value_out !== 32'd0) begin n_fail++; $display("FAIL x0_value: got %0d want 0", rif.value_out); end
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL nodest_pulse: got %b want 0", rif.rdy_commit_out); end
        n_cmp++; if (rif.rob_id_out !== 4'd1) begin n_fail++; $display("FAIL nodest_retired: got %0d want 1", rif.rob_id_out); end
        n_cmp++; if (rif.rob_id_dp_out !== 4'd2) begin n_fail++; $display("FAIL nodest_tail: got %0d want 2", rif.rob_id_dp_out); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        alloc(1, 5'd6, 0, 0);
        cdb(4'd0, 32'd55, 0, 0);
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b1) begin n_fail++; $display("FAIL hold_start: got %b want 1", rif.rdy_commit_out); end
        rif.rdy_in = 0;
        tick();
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b1 || rif.value_out !== 32'd55) begin n_fail++; $display("FAIL hold_kept: got %b/%0d want 1/55", rif.rdy_commit_out, rif.value_out); end
        rif.rdy_in = 1;
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", rif.rdy_commit_out); end
    endtask

    task automatic test_random();
        logic        r;
        logic [31:0] v;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rif.rdy_in = ($urandom_range(0, 9) != 0);
            rif.rdy_dp_in = ($urandom_range(0, 2) != 0);
            rif.has_dest_dp_in = $urandom_range(0, 1);
            rif.dest_dp_in = 5'($urandom_range(0, 31));
            rif.is_branch_dp_in = ($urandom_range(0, 7) == 0);
            rif.pred_taken_dp_in = $urandom_range(0, 1);
            rif.rdy_cdb_in = ($urandom_range(0, 9) < 7);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rif.rob_id_cdb_in = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
            else
                rif.rob_id_cdb_in = 4'($urandom_range(0, 15));
            rif.value_cdb_in = $urandom;
            rif.taken_cdb_in = $urandom_range(0, 1);
            rif.target_cdb_in = $urandom;
            rif.q1_id_in = ($urandom_range(0, 3) == 0) ? rif.rob_id_cdb_in : 4'($urandom_range(0, 15));
            rif.q2_id_in = 4'($urandom_range(0, 15));
            #1;
            model_lookup(rif.q1_id_in, r, v);
            n_cmp++; if (rif.q1_ready_out !== r || (r && rif.q1_val_out !== v)) begin n_fail++; $display("FAIL rnd_q1 c%0d: got %b/%h want %b/%h", c, rif.q1_ready_out, rif.q1_val_out, r, v); end
            model_lookup(rif.q2_id_in, r, v);
            n_cmp++; if (rif.q2_ready_out !== r || (r && rif.q2_val_out !== v)) begin n_fail++; $display("FAIL rnd_q2 c%0d: got %b/%h want %b/%h", c, rif.q2_ready_out, rif.q2_val_out, r, v); end
            tick();
            n_cmp++; if (rif.rdy_commit_out !== e_commit || rif.refresh_out !== e_refresh) begin n_fail++; $display("FAIL rnd_pulse c%0d: got %b/%b want %b/%b", c, rif.rdy_commit_out, rif.refresh_out, e_commit, e_refresh); end
            n_cmp++; if (rif.dest_out !== e_dest || rif.value_out !== e_value || rif.rob_id_out !== e_rid) begin n_fail++; $display("FAIL rnd_commit c%0d: got %0d/%h/%0d want %0d/%h/%0d", c, rif.dest_out, rif.value_out, rif.rob_id_out, e_dest, e_value, e_rid); end
            n_cmp++; if (rif.pc_out !== e_pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", c, rif.pc_out, e_pc); end
            n_cmp++; if (rif.full_out !== (mq.size() == 16) || rif.rob_id_dp_out !== 4'(m_tail)) begin n_fail++; $display("FAIL rnd_alloc c%0d: got %b/%0d want %b/%0d", c, rif.full_out, rif.rob_id_dp_out, mq.size() == 16, m_tail); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(1, 5'(i + 2), 0, 0);
        cdb(4'd0, 32'd11, 0, 0);
        rst = 1;
        rif.rdy_dp_in = 1;
        tick();
        rst = 0;
        rif.rdy_dp_in = 0;
        n_cmp++; if (rif.rob_id_dp_out !== 4'd0 || rif.full_out !== 1'b0 || rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got %0d/%b/%b want 0/0/0", rif.rob_id_dp_out, rif.full_out, rif.rdy_commit_out); end
        cdb(4'd1, 32'd12, 0, 0);
        tick();
        n_cmp++; if (rif.rdy_commit_out !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got %b want 0", rif.rdy_commit_out); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_wrap();
        test_bypass();
        test_mispredict();
        test_x0_nodest();
        test_rdy_hold();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order RV32I core. It allocates one entry per instruction issued by the dispatcher and captures results broadcast on the CDB. It retires completed entries in program order, one per cycle, into the register file commit port. On a branch mispredict it raises the flush (`refresh`) that clears the register file, the reservation stations and itself.

## Interface
Parameters:
- `ROB_WIDTH`, default 4: entry index width; depth = 2^ROB_WIDTH = 16.
- `REG_WIDTH`, default 5: architectural register index width.
- `DATA_WIDTH`, default 32: data and PC width.

Ports:
- `clk_in`  in  1  sole clock; all state changes on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable; when low, no register changes, including the pulse outputs.
- `rdy_dp_in`  in  1  dispatcher allocates an entry this cycle.
- `has_dest_dp_in`  in  1  the instruction writes `dest_dp_in`.
- `dest_dp_in`  in  REG_WIDTH  destination register.
- `is_branch_dp_in`  in  1  entry is a conditional branch or jalr.
- `pred_taken_dp_in`  in  1  prediction made at fetch.
- `rob_id_dp_out`  out  ROB_WIDTH  index the next allocation receives (= tail).
- `full_out`  out  1  count == 16; the dispatcher must not allocate.
- `q1_id_in`, `q2_id_in`  in  ROB_WIDTH  operand lookup indices.
- `q1_ready_out`, `q2_ready_out`  out  1  the looked-up entry holds its result.
- `q1_val_out`, `q2_val_out`  out  DATA_WIDTH  that result.
- `rdy_cdb_in`  in  1  CDB broadcast valid.
- `rob_id_cdb_in`  in  ROB_WIDTH  producing entry.
- `value_cdb_in`  in  DATA_WIDTH  result.
- `taken_cdb_in`  in  1  actual branch outcome.
- `target_cdb_in`  in  DATA_WIDTH  correct next PC for the branch.
- `rdy_commit_out`  out  1  one-cycle commit pulse to the register file.
- `dest_out`  out  REG_WIDTH  commit destination.
- `value_out`  out  DATA_WIDTH  commit value.
- `rob_id_out`  out  ROB_WIDTH  committed entry index.
- `refresh_out`  out  1  one-cycle flush pulse.
- `pc_out`  out  DATA_WIDTH  redirect PC, valid while `refresh_out` is high.

## Operation
- **Per-entry state:** `busy`, `ready`, `has_dest`, `dest`, `value`, `is_branch`, `pred_taken`, `taken`, `target`.
- **Pointers:**
  - `head` and `tail` are ROB_WIDTH bits and wrap naturally from 15 to 0.
  - `count` is ROB_WIDTH+1 bits.
- **Allocate** (`rdy_dp_in` && !`full_out`):
  - Entry[tail] is written with `busy`=1, `ready`=0 and the dispatch fields.
  - `tail`++ and `count`++.
  - Allocation while full is ignored.
- **CDB write:** when `rdy_cdb_in` is high and entry[rob_id_cdb_in] is busy, latch `value`, `taken` and `target`, and set `ready`=1. A write to a non-busy entry is ignored.
- **Lookup** (combinational):
  - `qN_ready_out` = entry.ready, or a same-cycle CDB hit on `qN_id_in`.
  - On a CDB hit, `qN_val_out` = `value_cdb_in`; otherwise it is the stored value.
- **Commit** when `count` > 0 and entry[head] is ready:
  - The entry is freed; `head`++ and `count`--.
  - `rdy_commit_out`=1, `dest_out`=entry.dest, `rob_id_out`=head.
  - `value_out`=entry.value, or 0 when `dest` is 0.
  - When `has_dest`=0, `rdy_commit_out` stays 0 but the entry still retires.
- **Mispredict:** the head entry is a branch with `taken` != `pred_taken`.
  - It commits as above (jalr writes its link register).
  - The same edge sets `refresh_out`=1 and `pc_out`=`target`.
  - The same edge clears every `busy`, sets `head`=`tail`=0 and `count`=0, and ignores any dispatch.
- **While `refresh_out` is high:** `rdy_dp_in` and `rdy_cdb_in` are ignored and nothing commits.
- **Simultaneous allocate and commit:** `count` is unchanged. Allocating while full is rejected even if a commit happens in the same cycle.

## Timing
- **Reset:** outputs clear at the first rising edge with `rst_in` high.
  - Pointers, `count`, `full_out`, `rdy_commit_out`, `refresh_out`, `pc_out`, `dest_out`, `value_out` and `rob_id_out` all become 0.
  - Every `busy` bit becomes 0.
  - Reset overrides `rdy_in`. Reset in the middle of operation discards all entries.
- **Allocation:** the entry written at edge N is visible to lookup and commit from cycle N+1.
- **Commit latency:** a CDB write at edge N sets `ready`. At edge N+1 the commit registers load, so the pulse is visible in cycle N+1→N+2. The minimum is one cycle from CDB to commit pulse.
- **Pulse length:** `rdy_commit_out` and `refresh_out` are high for exactly one `rdy_in`-high edge, then clear unless a new commit occurs.
- **`rdy_in` low:** pulses are held while `rdy_in` is low, so the consumer, also gated by `rdy_in`, sees each pulse exactly once.
- **Output sources:**
  - `full_out` and `rob_id_dp_out` derive from registered state only.
  - The lookup outputs are combinational.
  - The commit and refresh outputs are registered.
- **Throughput:** at most one commit per cycle.

## Test plan
- **Reset:** assert `rst_in` with `rdy_in`=0 → at the next edge all outputs are 0, `full_out`=0 and `rob_id_dp_out`=0.
- **In-order retirement:**
  - Stimulus: allocate three entries with dest x1, x2, x3; broadcast CDB results in order id2=30, id0=10, id1=20.
  - Required: commits x1=10, x2=20, x3=30 on consecutive cycles, with `rob_id_out` 0, 1, 2.
- **Fill and wrap:**
  - Allocate 16 entries → `full_out`=1 and a 17th allocation is ignored.
  - Complete and retire all 16, then allocate again → `rob_id_dp_out` wraps to 0 after 15.
- **Lookup bypass:** `q1_id_in`=5 while the CDB writes id 5 with 0xDEAD → `q1_ready_out`=1 and `q1_val_out`=0xDEAD in that same cycle.
- **Mispredict:**
  - Stimulus: a branch at the head with pred_taken=0 resolves taken with target 0x1000, and two younger entries are present.
  - Required: `refresh_out`=1 and `pc_out`=0x1000 for one cycle, then `count`=0 and `rob_id_dp_out`=0. A dispatch in the refresh cycle is dropped.
- **x0 and no-dest:**
  - An entry with dest x0 and value 7 → commits with `value_out`=0.
  - A store-type entry (`has_dest`=0) retires with no `rdy_commit_out` pulse.
